// File: rtl/uart_rx_frontend_if.sv
// Receive-side byte interface of the UART front end.
//   rx_data     received byte, valid while rx_valid=1
//   rx_valid    holding register full
//   rx_ready    consumer accepts the byte when rx_valid&rx_ready
//   framing_err 1-clk pulse, stop bit sampled low
//   overrun_err 1-clk pulse, byte completed while holding register full
//   busy        receiver not idle
// master = the receiver, slave = the consumer.
interface uart_rx_frontend_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 framing_err;
  logic                 overrun_err;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, framing_err, overrun_err, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, framing_err, overrun_err, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 serial receiver for the uart_rxd pin. It oversamples
// the line 16x, majority-votes three mid-bit samples and presents each byte
// through a one-deep valid/ready holding register with framing/overrun flags.
//   clk_clk      system clock, rising edge
//   reset_reset  synchronous active-high reset
//   rxd          asynchronous serial input, idle high
//   rx_if        byte/handshake/status interface (master side)
module uart_rx_frontend #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                rxd,
  uart_rx_frontend_if.master  rx_if
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state, w_next;
  logic                 r_sync1, r_sync2;
  logic [DW-1:0]        r_div;
  logic [3:0]           r_s;
  logic                 r_v7, r_v8;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_brk_ok;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame;
  logic                 r_over;

  logic w_rxs, w_tick, w_vote, w_s9, w_s15;
  logic w_clr_s, w_bit_clr, w_bit_inc, w_shift_en, w_deliver, w_frame;

  assign w_rxs  = r_sync2;
  assign w_tick = (r_div == DIV_LAST);
  assign w_s9   = w_tick && (r_s == 4'd9);
  assign w_s15  = w_tick && (r_s == 4'd15);
  // Third vote sample is the live line value on the s=9 tick itself.
  assign w_vote = (r_v7 & r_v8) | (r_v7 & w_rxs) | (r_v8 & w_rxs);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_clr_s    = 1'b0;
    w_bit_clr  = 1'b0;
    w_bit_inc  = 1'b0;
    w_shift_en = 1'b0;
    w_deliver  = 1'b0;
    w_frame    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr_s = 1'b1;
        if (!w_rxs) w_next = S_START;
      end
      S_START: begin
        if (w_s9 && w_vote) w_next = S_IDLE;
        else if (w_s15) begin
          w_next    = S_DATA;
          w_bit_clr = 1'b1;
        end
      end
      S_DATA: begin
        w_shift_en = w_s9;
        if (w_s15) begin
          if (r_bit == BIT_LAST) w_next = S_STOP;
          else                   w_bit_inc = 1'b1;
        end
      end
      S_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is caught.
        if (w_s9) begin
          if (w_vote) begin
            w_deliver = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_frame = 1'b1;
            w_next  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (w_tick && w_rxs && r_brk_ok) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_div    <= '0;
      r_s      <= '0;
      r_v7     <= 1'b1;
      r_v8     <= 1'b1;
      r_bit    <= '0;
      r_shift  <= '0;
      r_brk_ok <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_frame  <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_div   <= w_tick ? '0 : r_div + DW'(1);

      if (w_clr_s)     r_s <= '0;
      else if (w_tick) r_s <= r_s + 4'd1;

      if (w_tick && (r_s == 4'd7)) r_v7 <= w_rxs;
      if (w_tick && (r_s == 4'd8)) r_v8 <= w_rxs;

      if (w_bit_clr)      r_bit <= '0;
      else if (w_bit_inc) r_bit <= r_bit + BW'(1);

      // First bit on the wire ends up in the LSB after DATA_BITS shifts.
      if (w_shift_en) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};

      // Break exit needs the line high from one tick through the next.
      if ((r_state != S_BREAK) || !w_rxs) r_brk_ok <= 1'b0;
      else if (w_tick)                   r_brk_ok <= 1'b1;

      r_frame <= w_frame;
      r_over  <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_over <= 1'b1;
        end
      end else if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data     = r_data;
  assign rx_if.rx_valid    = r_valid;
  assign rx_if.framing_err = r_frame;
  assign rx_if.overrun_err = r_over;
  assign rx_if.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend at 1.6 MHz / 10 kbaud (160 clk per bit).
module tb_uart_rx_frontend;
  localparam int unsigned BIT_CLK = 160;
  // Stop-bit decision becomes visible this many clk after the start edge.
  localparam int unsigned LAT_LO  = 1530;
  localparam int unsigned LAT_HI  = 1547;

  typedef struct {
    logic [7:0]  data;
    bit          bad;
    int unsigned lo;
    int unsigned hi;
  } frame_t;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic rxd      = 1'b1;
  logic rx_ready = 1'b0;

  uart_rx_frontend_if #(.DATA_BITS(8)) rx_if ();
  assign rx_if.rx_ready = rx_ready;

  uart_rx_frontend #(
    .CLK_HZ(1_600_000),
    .BAUD(10_000),
    .OVERSAMPLE(16),
    .DATA_BITS(8)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .rxd(rxd),
    .rx_if(rx_if)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_t     q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_deliv  = 0;
  int         n_over   = 0;
  int         n_frame  = 0;
  logic [7:0] last_data = 8'h00;
  int         ready_mode = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  bit         p_valid = 1'b0;
  bit         p_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Consumer ready policy: 0 stall, 1 always ready, 2 sparse random accepts.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = ($urandom_range(0, 7) == 0);
    endcase
  end

  // Reference: an expected frame outcome is framing error if its stop bit
  // was low, else overrun if the holding register was full and not being
  // accepted, else a delivery of the frame byte.
  always @(negedge clk) begin
    logic       od, oo, of;
    logic [2:0] expk;
    frame_t     h;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      od = rx_if.rx_valid && (!p_valid || p_ready);
      oo = rx_if.overrun_err;
      of = rx_if.framing_err;
      if (od) begin
        n_deliv++;
        last_data = rx_if.rx_data;
      end
      if (oo) n_over++;
      if (of) n_frame++;
      if (od || oo || of) begin
        if (q.size() == 0) begin
          chk("spurious_event", 32'({of, oo, od}), 32'd0);
        end else begin
          h = q.pop_front();
          chk("event_before_window", 32'(cyc >= h.lo), 32'd1);
          chk("event_after_window", 32'(cyc <= h.hi), 32'd1);
          expk = h.bad ? 3'b100 : ((m_valid && !p_ready) ? 3'b010 : 3'b001);
          chk("event_kind", 32'({of, oo, od}), 32'(expk));
          if (expk == 3'b001) begin
            m_valid = 1'b1;
            m_data  = h.data;
          end else if (m_valid && p_ready) begin
            m_valid = 1'b0;
          end
        end
      end else begin
        if (m_valid && p_ready) m_valid = 1'b0;
        if (q.size() > 0 && cyc > q[0].hi) begin
          chk("frame_timeout", cyc, q[0].hi);
          void'(q.pop_front());
        end
      end
      chk("rx_valid", 32'(rx_if.rx_valid), 32'(m_valid));
      if (m_valid) chk("rx_data", 32'(rx_if.rx_data), 32'(m_data));
      p_valid = rx_if.rx_valid;
      p_ready = rx_ready;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_valid"}, 32'(rx_if.rx_valid), 32'd0);
    chk({tag, "_rx_data"}, 32'(rx_if.rx_data), 32'd0);
    chk({tag, "_busy"}, 32'(rx_if.busy), 32'd0);
    chk({tag, "_framing_err"}, 32'(rx_if.framing_err), 32'd0);
    chk({tag, "_overrun_err"}, 32'(rx_if.overrun_err), 32'd0);
  endtask

  // Drive one 8N1 frame. flip_bit inverts 10 clk around mid-bit of that bit;
  // abort_bit pulses reset halfway through that bit and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input bit bad, input int unsigned gap,
                            input int flip_bit, input int abort_bit);
    frame_t f;
    f.data = b;
    f.bad  = bad;
    f.lo   = cyc + LAT_LO;
    f.hi   = cyc + LAT_HI;
    if (abort_bit < 0) q.push_back(f);
    rxd = 1'b0;
    tick(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == abort_bit) begin
        tick(BIT_CLK / 2);
        chk("busy_mid_frame", 32'(rx_if.busy), 32'd1);
        q.delete();
        rst = 1'b1;
        rxd = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_outputs("midframe_reset");
        return;
      end
      if (i == flip_bit) begin
        tick(80);
        rxd = ~b[i];
        tick(10);
        rxd = b[i];
        tick(BIT_CLK - 90);
      end else begin
        tick(BIT_CLK);
      end
    end
    rxd = !bad;
    tick(BIT_CLK);
    rxd = 1'b1;
    tick(gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int d0, o0, f0;
    logic [7:0] rb;
    bit bad;
    int unsigned gap;

    rst = 1'b1;
    rxd = 1'b1;
    tick(5);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single byte, consumer always ready.
    ready_mode = 1;
    tick(20);
    d0 = n_deliv; o0 = n_over; f0 = n_frame;
    send_frame(8'hA5, 1'b0, 300, -1, -1);
    chk("t1_deliveries", 32'(n_deliv - d0), 32'd1);
    chk("t1_data", 32'(last_data), 32'hA5);
    chk("t1_no_errors", 32'((n_over - o0) + (n_frame - f0)), 32'd0);

    // Back-to-back frames against a stalled consumer.
    ready_mode = 0;
    tick(2);
    d0 = n_deliv; o0 = n_over; f0 = n_frame;
    send_frame(8'h3C, 1'b0, 0, -1, -1);
    send_frame(8'hC3, 1'b0, 300, -1, -1);
    chk("t2_overruns", 32'(n_over - o0), 32'd1);
    chk("t2_deliveries", 32'(n_deliv - d0), 32'd1);
    chk("t2_held_valid", 32'(rx_if.rx_valid), 32'd1);
    chk("t2_held_data", 32'(rx_if.rx_data), 32'h3C);
    ready_mode = 1;
    tick(4);
    chk("t2_drained", 32'(rx_if.rx_valid), 32'd0);

    // Low stop bit, then a good frame.
    d0 = n_deliv; o0 = n_over; f0 = n_frame;
    send_frame(8'h55, 1'b1, 2 * BIT_CLK, -1, -1);
    chk("t3_framing", 32'(n_frame - f0), 32'd1);
    chk("t3_no_delivery", 32'(n_deliv - d0), 32'd0);
    send_frame(8'h12, 1'b0, 300, -1, -1);
    chk("t3_deliveries", 32'(n_deliv - d0), 32'd1);
    chk("t3_data", 32'(last_data), 32'h12);
    chk("t3_no_overrun", 32'(n_over - o0), 32'd0);

    // 40-clk glitch while idle.
    d0 = n_deliv; o0 = n_over; f0 = n_frame;
    rxd = 1'b0;
    tick(20);
    chk("t4_busy_on_glitch", 32'(rx_if.busy), 32'd1);
    tick(20);
    rxd = 1'b1;
    tick(BIT_CLK - 40);
    chk("t4_busy_dropped", 32'(rx_if.busy), 32'd0);
    tick(400);
    chk("t4_no_events", 32'((n_deliv - d0) + (n_over - o0) + (n_frame - f0)), 32'd0);

    // Short disturbance inside bit 3 is outvoted.
    d0 = n_deliv;
    send_frame(8'hFF, 1'b0, 300, 3, -1);
    chk("t5_deliveries", 32'(n_deliv - d0), 32'd1);
    chk("t5_data", 32'(last_data), 32'hFF);

    // Reset during bit 4, then a clean frame.
    send_frame(8'h5A, 1'b0, 0, -1, 4);
    tick(400);
    d0 = n_deliv; o0 = n_over; f0 = n_frame;
    send_frame(8'h81, 1'b0, 300, -1, -1);
    chk("t6_deliveries", 32'(n_deliv - d0), 32'd1);
    chk("t6_data", 32'(last_data), 32'h81);
    chk("t6_no_errors", 32'((n_over - o0) + (n_frame - f0)), 32'd0);

    // Random bytes, gaps, stop-bit faults and consumer behaviour.
    for (int k = 0; k < 14; k++) begin
      ready_mode = int'($urandom_range(0, 2));
      rb  = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      gap = bad ? 200 + $urandom_range(0, 100) : $urandom_range(0, 200);
      send_frame(rb, bad, gap, -1, -1);
    end
    ready_mode = 1;
    tick(2000);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_valid", 32'(rx_if.rx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
